ifetch32: RTL and testbench

IFETCH32 -- requirements
Module: ifetch32

---
 rtl/ifetch32.sv | 170 +++++++++++++++++
 tb/tb_ifetch32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch32.sv
// ---------------------------------------------------------------------------
// ifetch32 -- instruction fetch unit for a 32-bit MIPS-style core.
//
// Fetches one instruction word at a time from a handshaked instruction ROM,
// holds it for decode/execute and, when the downstream stage retires it,
// computes the next program counter from the jump/branch controls that the
// decoder and ALU supply for that same instruction.
//
// Ports
//   clock             rising-edge system clock
//   reset             asynchronous active-low reset
//   rom_req           ROM read request (high for the whole fetch)
//   rom_adr[13:0]     ROM word address, always PC[15:2]
//   rom_ack           ROM data valid this cycle (only honoured while fetching)
//   rom_data[31:0]    ROM read word
//   Instruction[31:0] latched instruction word
//   inst_valid        Instruction is valid for decode/execute
//   stall             downstream hold; the instruction is not retired while high
//   branch_base_addr  PC+4 of the current instruction
//   Addr_result       branch target computed by execute
//   Read_data_1       rs value, used as the jr target
//   Branch, nBranch, Jmp, Jal, Jrn  decoded controls for Instruction
//   Zero              ALU zero flag for Instruction
//   link_addr         return address captured on a jal retire
//   pc_out            current PC
// ---------------------------------------------------------------------------
module ifetch32 (
  input  logic        clock,
  input  logic        reset,
  output logic        rom_req,
  output logic [13:0] rom_adr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic [31:0] Instruction,
  output logic        inst_valid,
  input  logic        stall,
  output logic [31:0] branch_base_addr,
  input  logic [31:0] Addr_result,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic        Zero,
  output logic [31:0] link_addr,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] link_q, link_d;
  logic        rom_req_q, rom_req_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        branch_taken_s;
  logic        retire_s;

  // Target word alignment drops the two low bits of both register-based
  // targets; they are deliberately ignored.
  logic        unused_bits_s;
  assign unused_bits_s = ^{Read_data_1[1:0], Addr_result[1:0]};

  // Sequential successor, wraps naturally at 2^32.
  assign pc_plus4_s = pc_q + 32'd4;

  // Either branch flavour may fire; both set together means "taken if
  // either condition holds".
  assign branch_taken_s = (Branch & Zero) | (nBranch & ~Zero);

  // Retire happens only on a non-stalled cycle in S_EXEC, so the branch
  // controls and Zero are effectively sampled on that edge alone.
  assign retire_s = (state_q == S_EXEC) && !stall;

  // Next-PC selection: jr beats j/jal beats conditional branch beats PC+4.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (Jrn) begin
      next_pc_s = {Read_data_1[31:2], 2'b00};
    end else if (Jmp || Jal) begin
      next_pc_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken_s) begin
      next_pc_s = {Addr_result[31:2], 2'b00};
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch FSM next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    link_d  = link_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (rom_ack) begin
          instr_d = rom_data;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_REQ;
        end
      end
      S_EXEC: begin
        if (retire_s) begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
          state_d = S_REQ;
          // jal links even when a simultaneous jr wins the target.
          if (Jal) begin
            link_d = pc_plus4_s;
          end else begin
            link_d = link_q;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // The request flop follows the state we are about to enter, so rom_req
    // rises in the same cycle S_REQ is entered.
    rom_req_d = (state_d == S_REQ);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      link_q    <= 32'd0;
      rom_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      link_q    <= link_d;
      rom_req_q <= rom_req_d;
    end
  end

  assign rom_req          = rom_req_q;
  assign rom_adr          = pc_q[15:2];
  assign Instruction      = instr_q;
  assign inst_valid       = valid_q;
  assign branch_base_addr = pc_plus4_s;
  assign link_addr        = link_q;
  assign pc_out           = pc_q;

endmodule

// File: tb/tb_ifetch32.sv
module tb_ifetch32;

  logic        clock;
  logic        reset;
  logic        rom_req;
  logic [13:0] rom_adr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic        stall;
  logic [31:0] branch_base_addr;
  logic [31:0] Addr_result;
  logic [31:0] Read_data_1;
  logic        Branch, nBranch, Jmp, Jal, Jrn, Zero;
  logic [31:0] link_addr;
  logic [31:0] pc_out;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_link;

  ifetch32 dut (
    .clock(clock), .reset(reset),
    .rom_req(rom_req), .rom_adr(rom_adr), .rom_ack(rom_ack), .rom_data(rom_data),
    .Instruction(Instruction), .inst_valid(inst_valid), .stall(stall),
    .branch_base_addr(branch_base_addr), .Addr_result(Addr_result),
    .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch),
    .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero),
    .link_addr(link_addr), .pc_out(pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_ctrl();
    Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jrn = 1'b0; Zero = 1'b0;
    Addr_result = 32'h0; Read_data_1 = 32'h0;
  endtask

  // Serve one ROM fetch: expect a request at exp_adr, answer after dly cycles.
  task automatic fetch(input logic [31:0] data, input int dly, input logic [13:0] exp_adr);
    int cnt;
    cnt = 0;
    while (rom_req !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("req_seen", {31'd0, rom_req}, 32'd1);
    chk("req_adr", {18'd0, rom_adr}, {18'd0, exp_adr});
    for (int i = 0; i < dly; i++) begin
      rom_ack = 1'b0;
      step();
      chk("req_hold", {31'd0, rom_req}, 32'd1);
      chk("adr_hold", {18'd0, rom_adr}, {18'd0, exp_adr});
    end
    rom_ack  = 1'b1;
    rom_data = data;
    exp_q.push_back(data);
    step();
    rom_ack  = 1'b0;
    rom_data = 32'h0;
    chk("valid_set", {31'd0, inst_valid}, 32'd1);
    chk("instr", Instruction, exp_q.pop_front());
    chk("req_drop", {31'd0, rom_req}, 32'd0);
  endtask

  // Retire the current instruction with the given controls.
  task automatic retire(input logic br, input logic nbr, input logic zr, input logic jmp,
                        input logic jal, input logic jrn, input logic [31:0] addr_res,
                        input logic [31:0] rd1, input logic [31:0] exp_pc,
                        input logic [31:0] exp_lnk);
    Branch = br; nBranch = nbr; Zero = zr; Jmp = jmp; Jal = jal; Jrn = jrn;
    Addr_result = addr_res; Read_data_1 = rd1;
    stall = 1'b0;
    step();
    clr_ctrl();
    chk("valid_clr", {31'd0, inst_valid}, 32'd0);
    chk("pc", pc_out, exp_pc);
    chk("next_adr", {18'd0, rom_adr}, {18'd0, exp_pc[15:2]});
    chk("link", link_addr, exp_lnk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    rom_ack = 1'b0;
    rom_data = 32'h0;
    stall = 1'b0;
    clr_ctrl();
    exp_link = 32'h0;

    // Reset state.
    step();
    step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_req", {31'd0, rom_req}, 32'd0);

    // Release: one idle cycle, then request at address 0.
    reset = 1'b1;
    chk("idle_req", {31'd0, rom_req}, 32'd0);
    step();
    chk("first_req", {31'd0, rom_req}, 32'd1);
    chk("first_adr", {18'd0, rom_adr}, 32'd0);

    // Sequential fetch.
    fetch(32'h2001_0001, 0, 14'h0);
    chk("bba0", branch_base_addr, 32'h4);
    retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, exp_link);
    fetch(32'h2002_0002, 0, 14'h1);
    chk("bba1", branch_base_addr, 32'h8);
    retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, exp_link);

    // jal at PC=8, target field 0x100.
    fetch(32'h0C00_0100, 0, 14'h2);
    exp_link = 32'h0000_000C;
    retire(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h400, exp_link);

    // beq taken / not taken, bne taken, both branch flags.
    fetch(32'h1000_0010, 0, 14'h100);
    retire(1, 0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h40, exp_link);
    fetch(32'h1000_0020, 0, 14'h10);
    retire(1, 0, 0, 0, 0, 0, 32'h80, 32'h0, 32'h44, exp_link);
    fetch(32'h1400_0030, 0, 14'h11);
    retire(0, 1, 0, 0, 0, 0, 32'h203, 32'h0, 32'h200, exp_link);
    fetch(32'h1400_0040, 0, 14'h80);
    retire(1, 1, 1, 0, 0, 0, 32'h300, 32'h0, 32'h300, exp_link);

    // jr wins over j; no link change.
    fetch(32'h0800_0ABC, 0, 14'hC0);
    retire(0, 0, 0, 1, 0, 1, 32'h0, 32'h123, 32'h120, exp_link);
    // jr wins over jal, but jal still links PC+4.
    fetch(32'h0C00_0ABC, 0, 14'h48);
    exp_link = 32'h124;
    retire(0, 0, 0, 0, 1, 1, 32'h0, 32'h1000, 32'h1000, exp_link);

    // Slow ROM, then a 4-cycle stall with distracting inputs.
    fetch(32'h0800_0010, 3, 14'h400);
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1;
      Branch = 1'b1; Zero = 1'b1; Addr_result = 32'h0000_0BAD; Jal = 1'b1;
      rom_ack = 1'b1; rom_data = 32'hFFFF_0000;
      step();
      chk("stall_instr", Instruction, 32'h0800_0010);
      chk("stall_pc", pc_out, 32'h1000);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_req", {31'd0, rom_req}, 32'd0);
      chk("stall_link", link_addr, exp_link);
    end
    rom_ack = 1'b0;
    rom_data = 32'h0;
    clr_ctrl();
    retire(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h40, exp_link);

    // Jump to the top word, then wrap sequentially to 0.
    fetch(32'h0000_0008, 0, 14'h10);
    retire(0, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, exp_link);
    fetch(32'h2003_0003, 0, 14'h3FFF);
    chk("bba_wrap", branch_base_addr, 32'h0);
    retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, exp_link);

    // Reset mid-fetch with an ack in flight.
    rom_ack = 1'b1;
    rom_data = 32'hDEAD_BEEF;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, rom_req}, 32'd0);
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_instr", Instruction, 32'h0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_link", link_addr, 32'h0);
    exp_link = 32'h0;
    step();
    chk("in_rst_instr", Instruction, 32'h0);
    rom_ack = 1'b0;
    rom_data = 32'h0;
    reset = 1'b1;
    chk("rel_req", {31'd0, rom_req}, 32'd0);
    step();
    chk("rel_req2", {31'd0, rom_req}, 32'd1);
    fetch(32'h2004_0004, 1, 14'h0);
    retire(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, exp_link);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
